// File: rtl/alu_drv_pkg.sv
// Shared types for the ALU command driver: FSM states, idle command and request bundle.
package alu_drv_pkg;

    localparam logic [5:0] NOP_CMD   = 6'b000000;
    localparam int         CNT_W     = 6;
    localparam int         DRV_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CAPTURE,
        RESP
    } DrvState;

    // Request bundle at the default datapath width; the top rebuilds it at its own WIDTH.
    typedef struct packed {
        logic [5:0]           cmd;
        logic [DRV_WIDTH-1:0] a;
        logic [DRV_WIDTH-1:0] b;
        logic [DRV_WIDTH-1:0] c;
    } drv_req_t;

endpackage

// File: rtl/alu_drv_req_buf.sv
// One-entry request holding register used when the driver accepts a request while busy.
module alu_drv_req_buf
    import alu_drv_pkg::*;
#(
    parameter type req_t = drv_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  req_t i_data,
    input  logic i_pop,
    output logic o_empty,
    output req_t o_data
);

    logic r_full;
    req_t r_data;

    // Push only happens while empty and pop only while full, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_push) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_empty = !r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/alu_cmd_driver.sv
// Host-side initiator for the ALU datapath: drive one command, wait RESULT_LAT, return the result.
// Optional one-entry request buffer enabled by defining ALU_DRV_REQ_BUF_EN.
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 1,
    parameter int RESULT_LAT  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [5:0]         req_cmd,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic [WIDTH-1:0]   req_c,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [2*WIDTH-1:0] resp_data,
    output logic               resp_zero,
    output logic               resp_error,
    output logic [5:0]         cmdin,
    output logic [WIDTH-1:0]   din_1,
    output logic [WIDTH-1:0]   din_2,
    output logic [WIDTH-1:0]   din_3,
    input  logic [WIDTH-1:0]   dout_low,
    input  logic [WIDTH-1:0]   dout_high,
    input  logic               zero,
    input  logic               error
);

    typedef struct packed {
        logic [5:0]       cmd;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } req_t;

    // r_cnt counts cycles since the first cycle cmdin carried the command.
    localparam logic [CNT_W-1:0] HOLD_N    = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(RESULT_LAT - 1);
    localparam DrvState          LAUNCH_ST = (RESULT_LAT == 1) ? CAPTURE : DRIVE;

    DrvState            r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [5:0]         r_cmdin;
    logic [WIDTH-1:0]   r_din_1;
    logic [WIDTH-1:0]   r_din_2;
    logic [WIDTH-1:0]   r_din_3;
    logic               r_resp_valid;
    logic [2*WIDTH-1:0] r_resp_data;
    logic               r_resp_zero;
    logic               r_resp_error;

    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_launch;
    req_t               w_req;
    req_t               w_src;

    assign w_req     = {req_cmd, req_a, req_b, req_c};
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

`ifdef ALU_DRV_REQ_BUF_EN
    logic w_buf_empty;
    logic w_push;
    logic w_pop;
    req_t w_buf_q;

    // Requests arriving while busy park in the buffer; an idle driver takes them directly.
    assign w_push   = req_valid && w_buf_empty && (r_state != IDLE);
    assign w_pop    = !w_buf_empty &&
                      ((r_state == IDLE) || ((r_state == RESP) && resp_ready));
    assign w_launch = w_pop || ((r_state == IDLE) && req_valid && w_buf_empty);
    assign w_src    = w_pop ? w_buf_q : w_req;
    assign req_ready = w_buf_empty;

    alu_drv_req_buf #(
        .req_t (req_t)
    ) u_req_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_empty (w_buf_empty),
        .o_data  (w_buf_q)
    );
`else
    assign w_launch  = (r_state == IDLE) && req_valid;
    assign w_src     = w_req;
    assign req_ready = (r_state == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cmdin      <= NOP_CMD;
            r_din_1      <= '0;
            r_din_2      <= '0;
            r_din_3      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_zero  <= 1'b0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                DRIVE, WAIT: begin
                    r_cnt <= w_cnt_nxt;
                    if (r_cnt == HOLD_LAST)
                        r_cmdin <= NOP_CMD;
                    if (w_cnt_nxt == LAT_LAST)
                        r_state <= CAPTURE;
                    else if (w_cnt_nxt < HOLD_N)
                        r_state <= DRIVE;
                    else
                        r_state <= WAIT;
                end
                CAPTURE: begin
                    // Also covers the HOLD_CYCLES == RESULT_LAT case, where DRIVE never clears cmdin.
                    r_cmdin      <= NOP_CMD;
                    r_cnt        <= '0;
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= {dout_high, dout_low};
                    r_resp_zero  <= zero;
                    r_resp_error <= error;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_launch) begin
                r_cmdin <= w_src.cmd;
                r_din_1 <= w_src.a;
                r_din_2 <= w_src.b;
                r_din_3 <= w_src.c;
                r_cnt   <= '0;
                r_state <= LAUNCH_ST;
            end
        end
    end

    assign cmdin      = r_cmdin;
    assign din_1      = r_din_1;
    assign din_2      = r_din_2;
    assign din_3      = r_din_3;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_zero  = r_resp_zero;
    assign resp_error = r_resp_error;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: latency-exact datapath model, response scoreboard, vector table.
module tb_alu_cmd_driver;

    localparam int W    = 8;
    localparam int HOLD = 1;
    localparam int RL   = 4;
`ifdef ALU_DRV_REQ_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid, req_ready, resp_valid, resp_ready;
    logic [5:0]   req_cmd, cmdin;
    logic [W-1:0] req_a, req_b, req_c, din_1, din_2, din_3, dout_low, dout_high;
    logic [2*W-1:0] resp_data;
    logic         resp_zero, resp_error, zero, error;

    always #5 clk = ~clk;

    alu_cmd_driver #(.WIDTH(W), .HOLD_CYCLES(HOLD), .RESULT_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_zero(resp_zero), .resp_error(resp_error),
        .cmdin(cmdin), .din_1(din_1), .din_2(din_2), .din_3(din_3),
        .dout_low(dout_low), .dout_high(dout_high), .zero(zero), .error(error)
    );

    typedef struct {
        logic [5:0]  cmd;
        logic [7:0]  a, b, c;
        logic [15:0] data;
        logic        z, e;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        z, e;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference ALU: {result[15:0], zero, error}
    function automatic logic [17:0] alu(input logic [5:0] cmd, input logic [7:0] a, b, c);
        logic [15:0] r;
        logic        e;
        e = 1'b0;
        case (cmd)
            6'h01:   r = 16'(a) + 16'(b) + 16'(c);
            6'h02:   r = 16'(a) - 16'(b);
            6'h03:   r = {8'h00, a ^ b ^ c};
            6'h05:   r = 16'(a) * 16'(b);
            default: begin r = 16'h0000; e = 1'b1; end
        endcase
        return {r, (r == 16'h0000), e};
    endfunction

    // Datapath model: the correct result is presented only in the cycle ending at the
    // edge RL cycles after cmdin first shows the command; otherwise its complement.
    logic [5:0]  m_cmd  = '0;
    logic [5:0]  m_prev = '0;
    int          m_age  = 0;
    int          m_w    = 0;
    logic [17:0] m_r;

    always @(negedge clk) begin
        if (rst) begin
            m_age  = 0;
            m_w    = 0;
            m_prev = '0;
        end else begin
            if (cmdin != 6'd0 && m_prev == 6'd0) begin
                m_cmd = cmdin;
                m_age = 1;
                m_w   = 1;
            end else begin
                if (m_age != 0) m_age++;
                if (m_age > RL) m_age = 0;
                if (cmdin != 6'd0) m_w++;
                else if (m_prev != 6'd0) check("cmd_hold", m_w, HOLD);
            end
            m_prev = cmdin;
        end
        m_r = alu(m_cmd, din_1, din_2, din_3);
        if (m_age == RL) {dout_high, dout_low, zero, error} = m_r;
        else             {dout_high, dout_low, zero, error} = ~m_r;
    end

    // Response scoreboard
    always @(negedge clk) begin
        exp_t ex;
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                ex = sb.pop_front();
                check("resp_data", resp_data, ex.data);
                check("resp_zero", resp_zero, ex.z);
                check("resp_error", resp_error, ex.e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] cmd, input logic [7:0] a, b, c,
                        input logic [15:0] d, input logic z, e);
        bit ok;
        exp_t ex;
        ok = 0;
        req_cmd = cmd; req_a = a; req_b = b; req_c = c;
        req_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                ex.data = d; ex.z = z; ex.e = e;
                sb.push_back(ex);
            end
        end
        if (!ok) check("req_timeout", 0, 1);
        step();
        req_valid = 1'b0;
        req_cmd = 6'h2A; req_a = 8'h5A; req_b = 8'hA5; req_c = 8'h3C;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
        step();
    endtask

    vec_t tbl[8];
`ifdef ALU_DRV_REQ_BUF_EN
    logic bseen;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{6'h05, 8'h03, 8'h04, 8'h00, 16'h000C, 1'b0, 1'b0};
        tbl[1] = '{6'h05, 8'hFF, 8'hFF, 8'h00, 16'hFE01, 1'b0, 1'b0};
        tbl[2] = '{6'h01, 8'h10, 8'h20, 8'h30, 16'h0060, 1'b0, 1'b0};
        tbl[3] = '{6'h01, 8'hFF, 8'hFF, 8'hFF, 16'h02FD, 1'b0, 1'b0};
        tbl[4] = '{6'h02, 8'h05, 8'h07, 8'h00, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{6'h03, 8'hAA, 8'h55, 8'hFF, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{6'h3F, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{6'h05, 8'h00, 8'h12, 8'h00, 16'h0000, 1'b1, 1'b0};

        req_valid = 1'b0; req_cmd = '0; req_a = '0; req_b = '0; req_c = '0;
        resp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_cmdin", cmdin, 0);
        check("rst_din", {din_1, din_2, din_3}, 0);
        step();
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_req_ready", req_ready, 1);
            check("idle_resp_valid", resp_valid, 0);
            check("idle_cmdin", cmdin, 0);
            check("idle_din", {din_1, din_2, din_3}, 0);
        end

        // Single request: exact cmdin pulse, operand hold and response timing
        step();
        resp_ready = 1'b1;
        send(6'h05, 8'h03, 8'h04, 8'h00, 16'h000C, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("t_cmdin", cmdin, (k == 1) ? 6'h05 : 6'h00);
            check("t_din_1", din_1, 8'h03);
            check("t_din_2", din_2, 8'h04);
            check("t_resp_valid", resp_valid, (k == 5));
            check("t_req_ready", req_ready, (BUF || k >= 6));
            if (k == 5) begin
                check("t_resp_data", resp_data, 16'h000C);
                check("t_resp_zero", resp_zero, 0);
            end
        end

        // Response backpressure
        step();
        resp_ready = 1'b0;
        send(6'h05, 8'hFF, 8'hFF, 8'h00, 16'hFE01, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
        check("bp_rise", resp_valid, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid", resp_valid, 1);
            check("bp_data", resp_data, 16'hFE01);
            check("bp_req_ready", req_ready, BUF);
            check("bp_cmdin", cmdin, 0);
        end
        step();
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_fall", resp_valid, 0);
        check("bp_ready_after", req_ready, 1);

        // Reset while waiting for the result: response is dropped
        step();
        send(6'h01, 8'h01, 8'h02, 8'h03, 16'h0006, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        for (int k = 0; k < RL + 6; k++) begin
            @(negedge clk);
            check("rst_mid_no_resp", resp_valid, 0);
            check("rst_mid_ready", req_ready, 1);
            check("rst_mid_cmdin", cmdin, 0);
        end
        step();
        send(6'h01, 8'h01, 8'h02, 8'h03, 16'h0006, 1'b0, 1'b0);
        drain();

        // Vector table
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].data, tbl[i].z, tbl[i].e);
            drain();
        end

`ifdef ALU_DRV_REQ_BUF_EN
        // Back-to-back requests: second parks in the buffer and launches right after the first handshake
        resp_ready = 1'b1;
        send(6'h05, 8'h06, 8'h07, 8'h00, 16'h002A, 1'b0, 1'b0);
        send(6'h03, 8'h0F, 8'hF0, 8'h01, 16'h00FE, 1'b0, 1'b0);
        bseen = 1'b0;
        for (int i = 0; i < 50 && !bseen; i++) begin
            @(negedge clk);
            bseen = resp_valid;
        end
        check("buf_first_resp", bseen, 1);
        @(negedge clk);
        check("buf_launch", cmdin, 6'h03);
        drain();
`endif

        repeat (3) step();
        check("end_queue_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
